// File: rtl/dmem_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Core-side zero-latency load hits; backing memory reached through a single-outstanding req/ack port.
module dmem_cache #(
  parameter int unsigned LINES = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  input  logic             inv_all,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, RFILL, WRITE, WDONE} state_t;

  state_t           state, state_nxt;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];
  logic             refill, refill_nxt;

  logic [IDX_W-1:0] idx, lidx;
  logic [TAG_W-1:0] tag, ltag;
  logic             hit, lhit;
  logic             mem_req_nxt, mem_we_nxt;
  logic             latch, fill, wupd, inv, hit_inc, miss_inc;
  logic             unused_addr_bits;

  // Live request decodes from the core; latched decodes from the outstanding memory address.
  assign idx  = cpu_addr[IDX_W+1:2];
  assign tag  = cpu_addr[31:IDX_W+2];
  assign lidx = mem_addr[IDX_W+1:2];
  assign ltag = mem_addr[31:IDX_W+2];
  assign hit  = valid[idx] && (tag_mem[idx] == tag);
  assign lhit = valid[lidx] && (tag_mem[lidx] == ltag);
  assign unused_addr_bits = ^cpu_addr[1:0];

  always_comb begin
    state_nxt   = state;
    mem_req_nxt = mem_req;
    mem_we_nxt  = mem_we;
    refill_nxt  = 1'b0;
    latch       = 1'b0;
    fill        = 1'b0;
    wupd        = 1'b0;
    inv         = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    cpu_stall   = 1'b0;
    cpu_rdata   = '0;
    case (state)
      IDLE: begin
        inv = inv_all;
        if (cpu_we) begin
          cpu_stall   = 1'b1;
          latch       = 1'b1;
          mem_req_nxt = 1'b1;
          mem_we_nxt  = 1'b1;
          state_nxt   = WRITE;
        end else if (cpu_re) begin
          if (hit) begin
            cpu_rdata = data_mem[idx];
            // The re-presented load right after a refill was already counted as a miss.
            hit_inc   = !refill;
          end else begin
            cpu_stall   = 1'b1;
            latch       = 1'b1;
            miss_inc    = 1'b1;
            mem_req_nxt = 1'b1;
            mem_we_nxt  = 1'b0;
            state_nxt   = RFILL;
          end
        end
      end
      RFILL: begin
        cpu_stall = 1'b1;
        if (mem_req && mem_ack) begin
          fill        = 1'b1;
          refill_nxt  = 1'b1;
          mem_req_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
      WRITE: begin
        cpu_stall = 1'b1;
        if (mem_req && mem_ack) begin
          wupd        = lhit;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          state_nxt   = WDONE;
        end
      end
      WDONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control, handshake and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= '0;
      refill    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      refill  <= refill_nxt;
      mem_req <= mem_req_nxt;
      mem_we  <= mem_we_nxt;
      if (latch) begin
        mem_addr <= {cpu_addr[31:2], 2'b00};
        if (cpu_we) mem_wdata <= cpu_wdata;
      end
      if (inv) valid <= '0;
      if (fill) valid[lidx] <= 1'b1;
      if (hit_inc && !(&hit_cnt)) hit_cnt <= hit_cnt + CNT_W'(1);
      if (miss_inc && !(&miss_cnt)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

  // Tag/data arrays need no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[lidx]  <= ltag;
      data_mem[lidx] <= mem_rdata;
    end else if (wupd) begin
      data_mem[lidx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_cache.sv
// Directed bench for dmem_cache: load data flows through a scoreboard queue,
// handshake, stall timing and counters are checked at each step.
module tb_dmem_cache;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset, cpu_re, cpu_we, inv_all, mem_ack;
  logic             cpu_stall, mem_req, mem_we;
  logic [31:0]      cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb [$];
  int          st, rq;

  always #5 clk = ~clk;

  dmem_cache #(.LINES(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .inv_all(inv_all), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a load at a negedge, ack the fill on the dly-th request cycle, compare data when the stall drops.
  task automatic do_load(input logic [31:0] a, input logic [31:0] fill, input int dly,
                         input logic [31:0] expd, output int stalls, output int reqs);
    int          budget;
    logic [31:0] e;
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    sb.push_back(expd);
    stalls = 0; reqs = 0; budget = 0;
    #1;
    while (cpu_stall && budget < 50) begin
      stalls++;
      if (mem_req) begin
        chk("ld_mem_addr", 64'(mem_addr), 64'({a[31:2], 2'b00}));
        chk("ld_mem_we", 64'(mem_we), 64'd0);
        reqs++;
        if (reqs == dly) begin mem_ack = 1'b1; mem_rdata = fill; end
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = '0;
      #1;
      budget++;
    end
    chk("ld_timeout", 64'(budget < 50), 64'd1);
    e = sb.pop_front();
    chk("ld_rdata", 64'(cpu_rdata), 64'(e));
    @(negedge clk);
    cpu_re = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int dly,
                          input logic re, output int stalls, output int reqs);
    int budget;
    cpu_re = re; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    stalls = 0; reqs = 0; budget = 0;
    #1;
    while (cpu_stall && budget < 50) begin
      stalls++;
      if (mem_req) begin
        chk("st_mem_addr", 64'(mem_addr), 64'({a[31:2], 2'b00}));
        chk("st_mem_we", 64'(mem_we), 64'd1);
        chk("st_mem_wdata", 64'(mem_wdata), 64'(d));
        reqs++;
        if (reqs == dly) mem_ack = 1'b1;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      budget++;
    end
    chk("st_timeout", 64'(budget < 50), 64'd1);
    chk("st_wdone_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    cpu_we = 1'b0; cpu_re = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; inv_all = 1'b0; mem_ack = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_hit", 64'(hit_cnt), 64'd0);
    chk("rst_miss", 64'(miss_cnt), 64'd0);

    // Cold miss, ack on first RFILL cycle, then a same-cycle hit.
    do_load(32'h40, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, st, rq);
    chk("miss1_stalls", 64'(st), 64'd2);
    chk("miss1_reqs", 64'(rq), 64'd1);
    chk("miss1_miss", 64'(miss_cnt), 64'd1);
    chk("miss1_hit", 64'(hit_cnt), 64'd0);
    do_load(32'h40, 32'h0, 1, 32'hDEAD_BEEF, st, rq);
    chk("hit1_stalls", 64'(st), 64'd0);
    chk("hit1_hit", 64'(hit_cnt), 64'd1);

    // Store hit with ack delayed to the third request cycle.
    do_store(32'h40, 32'h1234_5678, 3, 1'b0, st, rq);
    chk("st1_reqs", 64'(rq), 64'd3);
    chk("st1_stalls", 64'(st), 64'd4);
    do_load(32'h40, 32'h0, 1, 32'h1234_5678, st, rq);
    chk("st1_hit_reqs", 64'(rq), 64'd0);
    chk("st1_hit_stalls", 64'(st), 64'd0);
    chk("st1_hit_cnt", 64'(hit_cnt), 64'd2);

    // Store miss to an aliasing address: written through, not allocated, resident line untouched.
    do_store(32'h80, 32'hAAAA_5555, 1, 1'b0, st, rq);
    chk("st2_reqs", 64'(rq), 64'd1);
    chk("st2_stalls", 64'(st), 64'd2);
    do_load(32'h40, 32'h0, 1, 32'h1234_5678, st, rq);
    chk("st2_keep_stalls", 64'(st), 64'd0);
    do_load(32'h80, 32'hAAAA_5555, 1, 32'hAAAA_5555, st, rq);
    chk("noalloc_stalls", 64'(st), 64'd2);
    chk("noalloc_miss", 64'(miss_cnt), 64'd2);
    do_load(32'h40, 32'h1234_5678, 2, 32'h1234_5678, st, rq);
    chk("alias_stalls", 64'(st), 64'd3);
    chk("alias_miss", 64'(miss_cnt), 64'd3);
    chk("alias_hit", 64'(hit_cnt), 64'd3);

    // cpu_re and cpu_we together behave as a store that updates the resident line.
    do_store(32'h40, 32'hCAFE_F00D, 1, 1'b1, st, rq);
    chk("both_reqs", 64'(rq), 64'd1);
    chk("both_miss", 64'(miss_cnt), 64'd3);
    do_load(32'h40, 32'h0, 1, 32'hCAFE_F00D, st, rq);
    chk("both_hit_stalls", 64'(st), 64'd0);
    chk("both_hit_cnt", 64'(hit_cnt), 64'd4);

    // inv_all alongside a hit: the hit still uses pre-clear state; the next load misses.
    inv_all = 1'b1;
    do_load(32'h40, 32'h0, 1, 32'hCAFE_F00D, st, rq);
    inv_all = 1'b0;
    chk("inv_same_stalls", 64'(st), 64'd0);
    chk("inv_same_hit", 64'(hit_cnt), 64'd5);
    do_load(32'h40, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, st, rq);
    chk("inv_after_stalls", 64'(st), 64'd2);
    chk("inv_after_miss", 64'(miss_cnt), 64'd4);

    // Reset during RFILL, with a late ack on the following cycle.
    cpu_re = 1'b1; cpu_addr = 32'h100;
    @(negedge clk);
    #1;
    chk("rstmid_req_before", 64'(mem_req), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; cpu_re = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    #1;
    chk("rstmid_req", 64'(mem_req), 64'd0);
    chk("rstmid_stall", 64'(cpu_stall), 64'd0);
    chk("rstmid_hit", 64'(hit_cnt), 64'd0);
    chk("rstmid_miss", 64'(miss_cnt), 64'd0);
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    chk("late_ack_req", 64'(mem_req), 64'd0);
    chk("late_ack_stall", 64'(cpu_stall), 64'd0);
    do_load(32'h40, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, st, rq);
    chk("rstmid_inval_stalls", 64'(st), 64'd2);
    chk("rstmid_inval_miss", 64'(miss_cnt), 64'd1);

    // Stray ack while idle is ignored; misaligned load still hits.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("stray_ack_req", 64'(mem_req), 64'd0);
    do_load(32'h43, 32'h0, 1, 32'hCAFE_F00D, st, rq);
    chk("misalign_stalls", 64'(st), 64'd0);
    chk("misalign_hit", 64'(hit_cnt), 64'd1);

    // Saturation: 2^CNT_W+5 consecutive hits.
    cpu_re = 1'b1; cpu_addr = 32'h40;
    repeat ((1 << CNT_W) + 5) @(negedge clk);
    cpu_re = 1'b0;
    #1;
    chk("sat_hit", 64'(hit_cnt), 64'({CNT_W{1'b1}}));
    chk("sat_miss", 64'(miss_cnt), 64'd1);
    chk("sat_rdata_idle", 64'(cpu_rdata), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_cache.md
Name: dmem_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipelined core's memory stage and the slower backing data memory.
- Core side: MemWrite/address/WriteData/ReadData-style word interface plus a stall output that the hazard logic uses to freeze the pipeline.
- Memory side: single-outstanding req/ack word handshake.
- Includes saturating hit/miss counters for performance bring-up.

Parameters:
- LINES, 16, number of one-word cache lines; power of two, minimum 2; IDX_W = log2(LINES).
- CNT_W, 16, width of the hit and miss performance counters.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_re  input  1  load request from the memory stage.
- cpu_we  input  1  store request (MemWrite); has priority over cpu_re.
- cpu_addr  input  32  byte address (ALUResult); bits [1:0] are ignored.
- cpu_wdata  input  32  store data (WriteData).
- cpu_rdata  output  32  load data (ReadData); combinational.
- cpu_stall  output  1  combinational; the core must hold all cpu_* inputs stable while it is 1.
- mem_req  output  1  backing-memory request; registered state.
- mem_we  output  1  1 = write transaction, 0 = read.
- mem_addr  output  32  word-aligned address ({latched addr[31:2], 2'b00}).
- mem_wdata  output  32  write data.
- mem_rdata  input  32  read data; valid only when mem_ack=1.
- mem_ack  input  1  one-cycle completion pulse; ignored unless mem_req=1.
- inv_all  input  1  clears all valid bits next edge; only acted on in IDLE.
- hit_cnt  output  CNT_W  saturating count of load hits.
- miss_cnt  output  CNT_W  saturating count of load misses.

Behaviour:
- Address split: index = cpu_addr[IDX_W+1:2], tag = cpu_addr[31:IDX_W+2].
- Per-line storage: valid bit, tag, 32-bit data.
- hit = valid[index] and tag match.
- FSM states: IDLE, RFILL, WRITE, WDONE. On reset: state=IDLE, all valid=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, both counters=0.
- With no request: cpu_stall=0 and cpu_rdata=0.
- IDLE, load hit (cpu_re=1, cpu_we=0): cpu_rdata = line data in the same cycle, cpu_stall=0, hit_cnt+1.
  - Zero-latency hit.
- IDLE, load miss: cpu_stall=1, cpu_rdata=0.
  - Latch the address; miss_cnt+1.
  - Next state RFILL with mem_req=1, mem_we=0.
- RFILL: cpu_stall=1; mem_req held until mem_ack.
  - On mem_ack: write mem_rdata, tag and valid=1 into the line; mem_req=0; next state IDLE.
  - The re-presented load then hits; that hit does not increment hit_cnt (a one-cycle "refill" flag suppresses it).
  - Minimum load-miss penalty: 2 stall cycles (ack on the first RFILL cycle).
- IDLE, store (cpu_we=1, regardless of cpu_re): cpu_stall=1.
  - Latch address and data; next state WRITE with mem_req=1, mem_we=1.
- WRITE: cpu_stall=1.
  - On mem_ack: if the latched line is valid and its tag matches, update its data; otherwise leave the cache unchanged (no allocate).
  - mem_req=0; next state WDONE.
- WDONE: cpu_stall=0 for exactly one cycle, so the core retires the store; next state IDLE.
  - The store is never reissued. Minimum store cost: 2 stall cycles.
- inv_all in IDLE: clears all valid bits at the edge.
  - A request in the same cycle is still evaluated against the pre-clear state.
  - inv_all in any other state is ignored.
- Counters saturate at all-ones and never wrap.
- mem_ack while mem_req=0: ignored, with no state change.
- Reset mid-transaction: reset has priority in any state; next cycle is IDLE with mem_req=0 and the cache fully invalid.
  - The backing memory must tolerate an abandoned request; a late mem_ack is ignored.
- Misaligned cpu_addr[1:0] is ignored; no fault is raised.

Test Plan:
- Reset, then load 0x0000_0040 with mem_rdata=0xDEAD_BEEF and ack on the first RFILL cycle -> cpu_stall=1 for 2 cycles, mem_addr=0x40, mem_we=0; cpu_rdata=0xDEAD_BEEF with stall=0 on cycle 3; miss_cnt=1, hit_cnt=0. Repeat the load -> same-cycle hit, hit_cnt=1.
- Store 0x1234_5678 to 0x40 (line valid) with ack delayed 3 cycles -> mem_req/mem_we held 3 cycles, stall=1 for 4 cycles, then WDONE with stall=0. Next load of 0x40 hits and returns 0x1234_5678 with no mem_req.
- Store to 0x80 (not cached) -> one memory write issued; the following load of 0x80 misses (no allocate); miss_cnt increments.
- Aliasing with LINES=16: fill 0x40, then load 0x80 (same index 0, different tag) -> miss refills the line; load 0x40 again misses.
- Assert reset during RFILL with mem_ack arriving on the next cycle -> mem_req=0, state IDLE, late ack ignored, all lines invalid, counters 0.
- cpu_re=cpu_we=1 -> treated as a store. inv_all in IDLE then load of a cached address -> miss. Force 2^CNT_W+5 hits -> hit_cnt stays at all-ones.
